// File: rtl/logic_axi4_lite_bus_arbiter_scheduler.sv
// Round-robin write/read grant scheduler for one shared AXI4-Lite bus.
// Latency: request seen in cycle N -> grant in N+1; response done in M -> grant drops in M+1.
// Backpressure: the grant is held until the response handshake (or watchdog) completes.
//
// Ports: aclk/areset_n (async active-low); per direction a request vector, a
// registered one-hot grant and grant id, the shared-bus handshake done strobes,
// and a one-cycle timeout pulse.
// Optional watchdog: define LOGIC_AXI4_LITE_BUS_ARBITER_SCHEDULER_TIMEOUT_EN.

module logic_axi4_lite_bus_arbiter_scheduler_channel #(
    parameter int MASTERS       = 2,
    parameter int MASTERS_WIDTH = 1,
    parameter int TIMEOUT       = 256
) (
    input  logic                     aclk,
    input  logic                     areset_n,
    input  logic [MASTERS-1:0]       request,
    output logic [MASTERS-1:0]       grant,
    output logic [MASTERS_WIDTH-1:0] grant_id,
    input  logic                     address_done,
    input  logic                     data_done,
    input  logic                     response_done,
    output logic                     timeout
);
    typedef enum logic [1:0] {IDLE, ADDRESS, RESPONSE} state_t;

    state_t                     state_q, state_d;
    logic [MASTERS-1:0]         grant_q, grant_d;
    logic [MASTERS_WIDTH-1:0]   id_q, id_d;
    logic [MASTERS_WIDTH-1:0]   ptr_q, ptr_d;
    logic                       aseen_q, aseen_d;
    logic                       dseen_q, dseen_d;
    logic                       pick_vld;
    logic [MASTERS_WIDTH-1:0]   pick_id;
    logic [MASTERS_WIDTH-1:0]   ptr_next;
    logic                       expire;
    int                         j;

    // Walk downward so the lowest offset from the pointer is written last and wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        j        = 0;
        for (int i = MASTERS - 1; i >= 0; i--) begin
            j = int'(ptr_q) + i;
            if (j >= MASTERS) j = j - MASTERS;
            if (request[j[MASTERS_WIDTH-1:0]]) begin
                pick_vld = 1'b1;
                pick_id  = j[MASTERS_WIDTH-1:0];
            end
        end
    end

    // With a single master this folds to a constant 0 pointer.
    assign ptr_next = (id_q == MASTERS_WIDTH'(MASTERS - 1)) ? '0 : id_q + 1'b1;

`ifdef LOGIC_AXI4_LITE_BUS_ARBITER_SCHEDULER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    // Count of TIMEOUT-1 now means TIMEOUT busy cycles once this edge passes.
    assign expire = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= (state_q == IDLE) ? '0 : cnt_q + 1'b1;
            // A response completing on the expiry cycle wins over the watchdog.
            timeout_q <= expire && !(state_q == RESPONSE && response_done);
        end
    end
    assign timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        aseen_d = aseen_q;
        dseen_d = dseen_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d          = ADDRESS;
                    grant_d          = '0;
                    grant_d[pick_id] = 1'b1;
                    id_d             = pick_id;
                    aseen_d          = 1'b0;
                    dseen_d          = 1'b0;
                end
            end
            ADDRESS: begin
                if (expire) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_next;
                    aseen_d = 1'b0;
                    dseen_d = 1'b0;
                end else if ((aseen_q || address_done) && (dseen_q || data_done)) begin
                    state_d = RESPONSE;
                    aseen_d = 1'b0;
                    dseen_d = 1'b0;
                end else begin
                    aseen_d = aseen_q || address_done;
                    dseen_d = dseen_q || data_done;
                end
            end
            RESPONSE: begin
                if (response_done || expire) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_next;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            aseen_q <= 1'b0;
            dseen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            aseen_q <= aseen_d;
            dseen_q <= dseen_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = id_q;
endmodule

module logic_axi4_lite_bus_arbiter_scheduler #(
    parameter int MASTERS       = 2,
    parameter int MASTERS_WIDTH = (MASTERS >= 2) ? $clog2(MASTERS) : 1,
    parameter int TIMEOUT       = 256
) (
    input  logic                     aclk,
    input  logic                     areset_n,
    input  logic [MASTERS-1:0]       write_request,
    output logic [MASTERS-1:0]       write_grant,
    output logic [MASTERS_WIDTH-1:0] write_grant_id,
    input  logic                     write_address_done,
    input  logic                     write_data_done,
    input  logic                     write_response_done,
    output logic                     write_timeout,
    input  logic [MASTERS-1:0]       read_request,
    output logic [MASTERS-1:0]       read_grant,
    output logic [MASTERS_WIDTH-1:0] read_grant_id,
    input  logic                     read_address_done,
    input  logic                     read_response_done,
    output logic                     read_timeout
);
    logic_axi4_lite_bus_arbiter_scheduler_channel #(
        .MASTERS(MASTERS), .MASTERS_WIDTH(MASTERS_WIDTH), .TIMEOUT(TIMEOUT)
    ) u_write (
        .aclk          (aclk),
        .areset_n      (areset_n),
        .request       (write_request),
        .grant         (write_grant),
        .grant_id      (write_grant_id),
        .address_done  (write_address_done),
        .data_done     (write_data_done),
        .response_done (write_response_done),
        .timeout       (write_timeout)
    );

    // Reads have no data phase before the response, so that half of the
    // address-phase join is permanently satisfied.
    logic_axi4_lite_bus_arbiter_scheduler_channel #(
        .MASTERS(MASTERS), .MASTERS_WIDTH(MASTERS_WIDTH), .TIMEOUT(TIMEOUT)
    ) u_read (
        .aclk          (aclk),
        .areset_n      (areset_n),
        .request       (read_request),
        .grant         (read_grant),
        .grant_id      (read_grant_id),
        .address_done  (read_address_done),
        .data_done     (1'b1),
        .response_done (read_response_done),
        .timeout       (read_timeout)
    );
endmodule

// File: tb/tb_logic_axi4_lite_bus_arbiter_scheduler.sv
module tb_logic_axi4_lite_bus_arbiter_scheduler;
    localparam int MASTERS = 4;
    localparam int MW      = 2;
    localparam int TIMEOUT = 8;

    logic          aclk = 1'b0;
    logic          areset_n;
    logic [3:0]    write_request, write_grant, read_request, read_grant;
    logic [MW-1:0] write_grant_id, read_grant_id;
    logic          write_address_done, write_data_done, write_response_done, write_timeout;
    logic          read_address_done, read_response_done, read_timeout;

    int errors = 0;
    int checks = 0;
    int bad;

    logic_axi4_lite_bus_arbiter_scheduler #(.MASTERS(MASTERS), .TIMEOUT(TIMEOUT)) dut (
        .aclk                (aclk),
        .areset_n            (areset_n),
        .write_request       (write_request),
        .write_grant         (write_grant),
        .write_grant_id      (write_grant_id),
        .write_address_done  (write_address_done),
        .write_data_done     (write_data_done),
        .write_response_done (write_response_done),
        .write_timeout       (write_timeout),
        .read_request        (read_request),
        .read_grant          (read_grant),
        .read_grant_id       (read_grant_id),
        .read_address_done   (read_address_done),
        .read_response_done  (read_response_done),
        .read_timeout        (read_timeout)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        areset_n = 1'b0;
        write_request = '0; read_request = '0;
        write_address_done = 0; write_data_done = 0; write_response_done = 0;
        read_address_done = 0; read_response_done = 0;
        tick; tick;
        chk("rst_wgrant", 32'(write_grant), 0);
        chk("rst_rgrant", 32'(read_grant), 0);
        chk("rst_wid", 32'(write_grant_id), 0);
        chk("rst_rid", 32'(read_grant_id), 0);
        chk("rst_wto", 32'(write_timeout), 0);
        chk("rst_rto", 32'(read_timeout), 0);
        areset_n = 1'b1;
        tick;

        // Basic write: 0101 -> master 0, one bubble, then master 2.
        write_request = 4'b0101;
        tick;
        chk("w1_grant", 32'(write_grant), 32'b0001);
        chk("w1_id", 32'(write_grant_id), 0);
        write_address_done = 1; write_data_done = 1;
        tick;
        write_address_done = 0; write_data_done = 0;
        chk("w1_resp_hold", 32'(write_grant), 32'b0001);
        write_response_done = 1;
        tick;
        write_response_done = 0;
        chk("w1_bubble", 32'(write_grant), 0);
        tick;
        chk("w2_grant", 32'(write_grant), 32'b0100);
        chk("w2_id", 32'(write_grant_id), 2);
        write_request = 4'b0000;
        write_address_done = 1; write_data_done = 1;
        tick;
        write_address_done = 0; write_data_done = 0;
        write_response_done = 1;
        tick;
        write_response_done = 0;
        chk("w2_release", 32'(write_grant), 0);

        // Read grant held after the request drops (read pointer still 0).
        read_request = 4'b0100;
        tick;
        chk("rd_grant", 32'(read_grant), 32'b0100);
        chk("rd_id", 32'(read_grant_id), 2);
        read_request = 4'b0000;
        tick;
        chk("rd_drop_addr", 32'(read_grant), 32'b0100);
        read_address_done = 1;
        tick;
        read_address_done = 0;
        chk("rd_drop_resp", 32'(read_grant), 32'b0100);
        tick;
        chk("rd_drop_resp2", 32'(read_grant), 32'b0100);
        read_response_done = 1;
        tick;
        read_response_done = 0;
        chk("rd_release", 32'(read_grant), 0);

        // Data done two cycles before address done (write pointer now 3 -> master 1).
        write_request = 4'b0010;
        tick;
        chk("ord_grant", 32'(write_grant), 32'b0010);
        write_data_done = 1;
        tick;
        write_data_done = 0;
        write_response_done = 1;   // still in ADDRESS: must not release
        tick;
        write_response_done = 0;
        chk("ord_addr_hold", 32'(write_grant), 32'b0010);
        write_address_done = 1;
        tick;
        write_address_done = 0;
        chk("ord_resp_hold", 32'(write_grant), 32'b0010);
        write_response_done = 1;
        tick;
        write_response_done = 0;
        chk("ord_release", 32'(write_grant), 0);

        // Both done in the same cycle.
        tick;
        chk("same_grant", 32'(write_grant), 32'b0010);
        write_address_done = 1; write_data_done = 1;
        tick;
        write_address_done = 0; write_data_done = 0;
        chk("same_resp_hold", 32'(write_grant), 32'b0010);
        write_response_done = 1;
        tick;
        write_response_done = 0;
        chk("same_release", 32'(write_grant), 0);

        // Reset while in RESPONSE clears grants at once.
        tick;
        chk("rst2_pre_grant", 32'(write_grant), 32'b0010);
        write_address_done = 1; write_data_done = 1;
        tick;
        write_address_done = 0; write_data_done = 0;
        write_request = 4'b0000;
        areset_n = 1'b0;
        #1;
        chk("rst2_wgrant", 32'(write_grant), 0);
        chk("rst2_rgrant", 32'(read_grant), 0);
        tick;
        areset_n = 1'b1;

        // Fairness: all masters on both directions, overlapping.
        write_request = 4'b1111;
        read_request  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("rr_wgrant", 32'(write_grant), 32'd1 << (k % 4));
            chk("rr_wid", 32'(write_grant_id), 32'(k % 4));
            chk("rr_rgrant", 32'(read_grant), 32'd1 << (k % 4));
            chk("rr_rid", 32'(read_grant_id), 32'(k % 4));
            write_address_done = 1; write_data_done = 1; read_address_done = 1;
            tick;
            write_address_done = 0; write_data_done = 0; read_address_done = 0;
            chk("rr_whold", 32'(write_grant), 32'd1 << (k % 4));
            write_response_done = 1; read_response_done = 1;
            tick;
            write_response_done = 0; read_response_done = 0;
            chk("rr_wbubble", 32'(write_grant), 0);
            chk("rr_rbubble", 32'(read_grant), 0);
        end

        // Watchdog: masters 1 and 2 request, no completion (pointer is 1).
        write_request = 4'b0110;
        read_request  = 4'b0000;
        tick;
        chk("to_grant", 32'(write_grant), 32'b0010);
`ifdef LOGIC_AXI4_LITE_BUS_ARBITER_SCHEDULER_TIMEOUT_EN
        bad = 0;
        for (int c = 1; c < TIMEOUT; c++) begin
            tick;
            if (write_grant !== 4'b0010 || write_timeout !== 1'b0) bad++;
        end
        chk("to_wait", 32'(bad), 0);
        tick;
        chk("to_pulse", 32'(write_timeout), 1);
        chk("to_cleared", 32'(write_grant), 0);
        tick;
        chk("to_pulse_end", 32'(write_timeout), 0);
        chk("to_next", 32'(write_grant), 32'b0100);
        chk("to_rto", 32'(read_timeout), 0);
`else
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            tick;
            if (write_grant !== 4'b0010 || write_timeout !== 1'b0 || read_timeout !== 1'b0) bad++;
        end
        chk("hold_1000", 32'(bad), 0);
        chk("hold_id", 32'(write_grant_id), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/logic_axi4_lite_bus_arbiter_scheduler.md
# logic_axi4_lite_bus_arbiter_scheduler

Round-robin scheduler that shares one AXI4-Lite bus between `MASTERS` requesters, with independent write and read directions. It sits in front of the multi-slave address decoder and drives the mux selects for the shared bus. The grant is held for one complete transaction per direction, because AXI4-Lite allows only one outstanding access. An optional watchdog releases a grant whose response never arrives.

## Interface
- `MASTERS`, default 2: number of requesting masters, valid range 1 to 64.
- `MASTERS_WIDTH`, default `(MASTERS >= 2) ? $clog2(MASTERS) : 1`: width of the grant id.
- `TIMEOUT`, default 256: watchdog limit in cycles, must be at least 2. Used only when the timeout feature is compiled in.

Ports:
- `aclk`  in  1  clock.
- `areset_n`  in  1  reset, asynchronous, active-low.
- `write_request`  in  MASTERS  per-master `awvalid`.
- `write_grant`  out  MASTERS  one-hot write grant, registered.
- `write_grant_id`  out  MASTERS_WIDTH  index of the write winner, registered.
- `write_address_done`  in  1  shared-bus `awvalid && awready`.
- `write_data_done`  in  1  shared-bus `wvalid && wready`.
- `write_response_done`  in  1  shared-bus `bvalid && bready`.
- `write_timeout`  out  1  one-cycle pulse when the write watchdog expires.
- `read_request`  in  MASTERS  per-master `arvalid`.
- `read_grant`  out  MASTERS  one-hot read grant, registered.
- `read_grant_id`  out  MASTERS_WIDTH  index of the read winner, registered.
- `read_address_done`  in  1  shared-bus `arvalid && arready`.
- `read_response_done`  in  1  shared-bus `rvalid && rready`.
- `read_timeout`  out  1  one-cycle pulse when the read watchdog expires.

## Operation
- The write and read directions are two identical, independent FSMs with states IDLE, ADDRESS and RESPONSE. They never block each other.
- Reset:
  - state is IDLE;
  - grant is `'0` and grant id is `'0`;
  - timeout outputs are 0;
  - the round-robin pointer is 0, so master 0 has top priority.
- IDLE:
  - if any request bit is set, the first set bit searching upward from the pointer (with wrap-around) wins;
  - grant, grant id and state ADDRESS are registered in the same clock edge.
- Write ADDRESS:
  - two sticky flags record `write_address_done` and `write_data_done`;
  - the done signals may arrive in either order or in the same cycle;
  - once both are seen (flag set or input high this cycle), go to RESPONSE and clear the flags.
- Read ADDRESS: `read_address_done` moves the FSM to RESPONSE.
- RESPONSE:
  - the response done signal moves the FSM to IDLE;
  - grant is cleared and the pointer is set to winner+1, wrapping modulo `MASTERS`.
- The grant is held whatever the request line does after the grant is issued. Dropping a request mid-transaction does not release the grant.
- A done input that arrives while in IDLE is ignored.
- With `MASTERS` = 1, the pointer is constant 0 and the grant id is always 0.

## Timing
- A request first seen in cycle N gives a grant that is visible in cycle N+1.
- A response done in cycle M deasserts the grant in cycle M+1. The next grant is visible in cycle M+2, giving exactly one idle bubble.
- Minimum write transaction, counted from the grant:
  - 1 cycle in ADDRESS, with both done signals in the same cycle;
  - 1 cycle in RESPONSE.
- A grant never changes while the FSM is in ADDRESS or RESPONSE.
- `write_grant_id` always matches `write_grant`; the read pair follows the same rule.
- Fairness: with all masters requesting continuously, grants rotate 0, 1, …, MASTERS-1, 0.
- Asserting reset mid-transaction immediately clears grants, flags, counters and the pointer.

## Configuration
- Macro `LOGIC_AXI4_LITE_BUS_ARBITER_SCHEDULER_TIMEOUT_EN` enables the watchdog.
- With the macro defined:
  - each direction has a counter of width `$clog2(TIMEOUT+1)`;
  - the counter clears on grant and increments every cycle in ADDRESS or RESPONSE;
  - when the count reaches `TIMEOUT` without completion, the timeout output pulses for one cycle;
  - the FSM returns to IDLE, the grant is cleared in that same edge, and the pointer advances as on a normal completion;
  - a completion in the same cycle as expiry counts as a completion, so no pulse is produced.
- Without the macro, no counter exists, the timeout outputs are constant 0, `TIMEOUT` is ignored, and a grant waits forever.

## Test plan
- Reset, then `MASTERS`=4 with `write_request`=4'b0101 → `write_grant`=4'b0001 next cycle. After the address, data and response done signals, one idle cycle, then 4'b0100.
- All four masters requesting on both directions continuously → write and read grants each cycle through ids 0, 1, 2, 3, 0, and the two directions overlap freely.
- Write with `write_data_done` 2 cycles before `write_address_done` → the FSM enters RESPONSE in the cycle after `write_address_done`. Both in the same cycle → the same result.
- Master 2 drops `read_request` after its grant → `read_grant` stays 4'b0100 until `read_response_done`.
- Macro on, `TIMEOUT`=8, no `write_response_done` → `write_timeout` pulses exactly once, 8 cycles after the grant, the grant clears and the next requester wins. Macro off → the grant is held for 1000 cycles.
- `areset_n` asserted while in RESPONSE → grants are 0 immediately. After release, master 0 wins first.
